// File: rtl/dcp_run_ctrl.sv
// Run controller: gates the CPU clock for single-step and run-to-breakpoint, owns the breakpoint file.
// Latency: first clk_cpu rise 1 cycle after start; each clk_cpu period is 2*HALF+1 cycles; done 1 cycle after the deciding CHECK.
// Backpressure: none; start is ignored while busy, abort is latched until the next CHECK.
module dcp_run_ctrl #(
    parameter int NUM_BP = 4,
    parameter int HALF   = 2,
    parameter int TMO_W  = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      abort,
    input  logic                      bp_we,
    input  logic [$clog2(NUM_BP)-1:0] bp_idx,
    input  logic [31:0]               bp_addr,
    input  logic                      bp_en,
    input  logic                      bp_clr,
    input  logic                      pc_chk,
    input  logic [31:0]               pc,
    output logic                      clk_cpu,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                reason,
    output logic [$clog2(NUM_BP)-1:0] hit_idx,
    output logic [TMO_W-1:0]          cyc_cnt
);

    localparam int IDX_W = $clog2(NUM_BP);
    localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

    localparam logic [1:0] RSN_STEP  = 2'b00;
    localparam logic [1:0] RSN_BP    = 2'b01;
    localparam logic [1:0] RSN_ABORT = 2'b10;
    localparam logic [1:0] RSN_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic               mode_q, mode_d;
    logic               abort_q, abort_d;
    logic [TMO_W-1:0]   cyc_q, cyc_d;
    logic [1:0]         reason_q, reason_d;
    logic [IDX_W-1:0]   hit_q, hit_d;
    logic               clk_cpu_q, clk_cpu_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_BP-1:0]  bp_en_q;
    logic [31:0]        bp_addr_q [NUM_BP];

    logic               bp_hit;
    logic [IDX_W-1:0]   bp_hit_idx;
    logic               cyc_sat;

    assign cyc_sat = &cyc_q;

    // Breakpoint file: a clear and a write in the same cycle leave the written slot with the written enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_en_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            if (bp_clr) begin
                bp_en_q <= '0;
            end
            if (bp_we) begin
                bp_addr_q[bp_idx] <= bp_addr;
                bp_en_q[bp_idx]   <= bp_en;
            end
        end
    end

    // Breakpoint compare: scan from the top so the lowest matching slot wins.
    always_comb begin
        bp_hit     = 1'b0;
        bp_hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
                bp_hit     = 1'b1;
                bp_hit_idx = IDX_W'(i);
            end
        end
    end

    // Sequencer next state: clock phases, exit evaluation in CHECK, and registered output values.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        mode_d   = mode_q;
        abort_d  = abort_q;
        cyc_d    = cyc_q;
        reason_d = reason_q;
        hit_d    = hit_q;

        // abort only counts once a run is under way
        if ((state_q != S_IDLE) && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    abort_d = 1'b0;
                    cyc_d   = TMO_W'(1);
                    hcnt_d  = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (hcnt_q == HLAST) begin
                    hcnt_d  = '0;
                    state_d = S_LOW;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_LOW: begin
                if (hcnt_q == HLAST) begin
                    hcnt_d  = '0;
                    state_d = S_CHECK;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (abort_q || abort) begin
                    reason_d = RSN_ABORT;
                    state_d  = S_DONE;
                end else if (mode_q && pc_chk && bp_hit) begin
                    reason_d = RSN_BP;
                    hit_d    = bp_hit_idx;
                    state_d  = S_DONE;
                end else if (!mode_q && pc_chk) begin
                    reason_d = RSN_STEP;
                    state_d  = S_DONE;
                end else if (cyc_sat) begin
                    reason_d = RSN_TMO;
                    state_d  = S_DONE;
                end else begin
                    cyc_d   = cyc_q + 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        clk_cpu_d = (state_d == S_HIGH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; reset drops clk_cpu at once and suppresses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            mode_q    <= 1'b0;
            abort_q   <= 1'b0;
            cyc_q     <= '0;
            reason_q  <= RSN_STEP;
            hit_q     <= '0;
            clk_cpu_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            mode_q    <= mode_d;
            abort_q   <= abort_d;
            cyc_q     <= cyc_d;
            reason_q  <= reason_d;
            hit_q     <= hit_d;
            clk_cpu_q <= clk_cpu_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign clk_cpu = clk_cpu_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign reason  = reason_q;
    assign hit_idx = hit_q;
    assign cyc_cnt = cyc_q;

endmodule

// File: doc/dcp_run_ctrl.md
Name: dcp_run_ctrl

Overview:
- Run controller for the debug control unit. It generates the gated CPU clock `clk_cpu` for the multi-cycle CPU under debug and sequences it for two operations: single-instruction step (T command) and free run until breakpoint or abort (G/B commands).
- It owns the breakpoint register file and reports why the CPU stopped. The DCP command FSM drives `start`, `mode` and breakpoint writes, then waits for `done`.

Parameters:
- NUM_BP, 4, number of breakpoint slots (power of 2, 2..16).
- HALF, 2, clk cycles per `clk_cpu` half-period (>=1).
- TMO_W, 24, width of the run cycle counter; the run times out when the counter saturates at 2^TMO_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- mode  in  1  0=STEP (one instruction), 1=GO (run to breakpoint)
- abort  in  1  one-cycle request to stop a GO/STEP run
- bp_we  in  1  write strobe for one breakpoint slot
- bp_idx  in  log2(NUM_BP)  slot index for a write
- bp_addr  in  32  breakpoint PC value
- bp_en  in  1  enable bit written with bp_addr
- bp_clr  in  1  clears all enable bits
- pc_chk  in  1  CPU is at an instruction boundary (fetch state)
- pc  in  32  current CPU PC
- clk_cpu  out  1  gated CPU clock
- busy  out  1  run in progress (any state except IDLE)
- done  out  1  one-cycle pulse when a run ends
- reason  out  2  00 step complete, 01 breakpoint hit, 10 abort, 11 timeout; held until the next `done`
- hit_idx  out  log2(NUM_BP)  slot index that hit; valid when reason=01
- cyc_cnt  out  TMO_W  `clk_cpu` rising edges issued in the current or last run

Behaviour:
- Reset is asynchronous, active-high; clock is `clk`.
- Reset values:
  - state IDLE
  - `clk_cpu`=0, `busy`=0, `done`=0, `reason`=00, `hit_idx`=0, `cyc_cnt`=0
  - all breakpoint enables 0, breakpoint addresses 0
  - abort latch 0
- Reset mid-run: `clk_cpu` drops to 0 immediately and no `done` pulse is produced.
- States and transitions:
  - **IDLE:** `clk_cpu`=0. On `start`: latch `mode`, clear `cyc_cnt` and the abort latch, go to HIGH.
  - **HIGH:** `clk_cpu`=1 for HALF cycles. `cyc_cnt` increments (saturating) on entry. Then go to LOW.
  - **LOW:** `clk_cpu`=0 for HALF cycles. Then go to CHECK.
  - **CHECK:** one cycle, `clk_cpu`=0. Evaluate the exit conditions in the priority order below; if one fires go to DONE, else go to HIGH.
    1. abort latched -> reason 10
    2. mode=GO & `pc_chk` & any enabled slot with bp_addr==`pc` -> reason 01; `hit_idx` = lowest matching index
    3. mode=STEP & `pc_chk` -> reason 00
    4. `cyc_cnt` saturated -> reason 11
  - **DONE:** one cycle, `done`=1, `clk_cpu`=0. Then go to IDLE. `busy` falls in the cycle after DONE.
- Clock period: each `clk_cpu` period is 2*HALF+1 clk cycles (HIGH, LOW, CHECK). The first rising edge occurs 1 cycle after `start`.
- Breakpoints are checked only after at least one `clk_cpu` edge. A GO started at a PC equal to an enabled breakpoint executes that instruction and does not hit immediately.
- STEP ignores breakpoints.
- `start` while not IDLE: ignored.
- `abort` in IDLE: ignored. `abort` in any other state: latched and acted on at the next CHECK. `abort` arriving in the same cycle as a CHECK is taken in that CHECK.
- Breakpoint writes are accepted in any state and take effect at the next CHECK.
  - `bp_we` and `bp_clr` in the same cycle: `bp_clr` is applied first, then the write, so the written slot ends with the written enable.
- `pc_chk` and `pc` are sampled only in CHECK.

Test Plan:
- Reset, then STEP (mode=0, start). CPU model asserts `pc_chk` on the 5th edge -> exactly 5 `clk_cpu` pulses, each high 2 / low 3 cycles; `done` 1 cycle; reason=00; `cyc_cnt`=5.
- bp slot 2 = 0x0000_3010 enabled, slot 0 = 0x0000_3010 disabled; GO with PC sequence 0x3000, 0x3004, ..., `pc_chk` every 3 edges -> stop when pc=0x3010; reason=01, `hit_idx`=2, `clk_cpu` low after stop.
- Slots 1 and 3 both = 0x3008 and enabled -> `hit_idx`=1. After `bp_clr`, GO the same program -> no hit; `abort` pulse -> next CHECK ends the run with reason=10.
- GO starting at pc=0x3010 with a breakpoint at 0x3010 -> no hit on the first boundary; the run continues.
- TMO_W=4, GO with no breakpoint -> `done` after 15 edges, reason=11, `cyc_cnt`=15.
- `start` pulsed while busy -> ignored. `rst` asserted mid-HIGH -> `clk_cpu`=0 and `busy`=0 immediately, no `done`; the next STEP run works normally.
